led_pwm_mod: RTL and testbench
==============================

LED_PWM_MOD -- requirements
Module: led_pwm_mod

Interface
REQ-001 Parameter: PRESC, default 4, number of clk cycles per PWM counter step; legal range 1..65535.
REQ-002 Port: clk  input  1  sole clock; all logic samples on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: en  input  1  modulator enable.
REQ-005 Port: ch_sel  input  3  target channel for a duty write.
REQ-006 Port: duty_in  input  8  duty value; 0 = off, 255 = fully on.
REQ-007 Port: duty_valid  input  1  write request qualifier.
REQ-008 Port: duty_ready  output  1  block can accept a write this cycle.
REQ-009 Port: pwm_out  output  8  per-channel PWM drive, bit i = channel i.
REQ-010 Port: period_tick  output  1  one-cycle pulse marking the start of a new PWM period.

Function
REQ-011 The block SHALL hold a prescale counter pc (0..PRESC-1), a step flag step = en && (pc == PRESC-1), and an 8-bit period counter cnt (0..254).
REQ-012 When en=1, pc SHALL increment each clk and wrap PRESC-1 -> 0; cnt SHALL increment on step and wrap 254 -> 0, giving a period of 255*PRESC clk cycles.
REQ-013 When en=0, pc and cnt SHALL be cleared to 0 on the next clk, pwm_out SHALL be cleared to 8'h00, and no commit SHALL occur.
REQ-014 Each channel SHALL have an 8-bit shadow register and an 8-bit active register.
REQ-015 A write SHALL occur when duty_valid && duty_ready: shadow[ch_sel] <= duty_in; other shadows are unchanged; writes are accepted regardless of en.
REQ-016 The commit cycle SHALL be defined as step && (cnt == 254); in it, all eight active registers SHALL load from their shadows simultaneously.
REQ-017 duty_ready SHALL be combinational and equal to !(step && cnt == 254); it is low only in the commit cycle.
REQ-018 A request held across the commit cycle SHALL be accepted in the following cycle, with its value first applied at the subsequent commit.
REQ-019 period_tick SHALL be a registered pulse, high for exactly the one clk following each commit cycle, which is the first cycle with cnt == 0.
REQ-020 pwm_out[i] SHALL be registered: when en=1, pwm_out[i] <= (cnt < active[i]) each clk, giving one clk of latency behind cnt.
REQ-021 Per period, channel i SHALL be high for exactly active[i]*PRESC clk cycles.
REQ-022 Duty 0 SHALL give a constant low output, and duty 255 SHALL give a constant high output with no glitch at the wrap.
REQ-023 Comparisons SHALL be unsigned 8-bit, with no saturation or overflow paths.
REQ-024 A shadow write landing in the same cycle as a commit is impossible by REQ-017, and none SHALL be created by any other path.

Reset
REQ-025 On rst=1 at a clk edge, the following SHALL be cleared to 0: pc, cnt, all shadow and active registers, pwm_out, and period_tick.
REQ-026 Reset SHALL take priority over en, writes and commits, including when asserted mid-period or in a commit cycle.
REQ-027 During rst=1, duty_ready SHALL still follow REQ-017, which evaluates to 1 because the counters are 0; writes presented during reset SHALL be discarded.
REQ-028 After rst deasserts with en=1, the first period SHALL start at cnt=0 with all active duties 0 until the first commit.

Verification
REQ-029 PRESC=1, reset, en=1, write ch0=128 at cycle 0 -> pwm_out[0] stays 0 through the first period; after the first period_tick it is high for 128 cycles and low for 127 cycles, repeating.
REQ-030 PRESC=1, write ch1=0 and ch2=255, wait one commit -> pwm_out[1] is constantly 0 and pwm_out[2] is constantly 1 across at least 3 periods, including the wrap cycle.
REQ-031 PRESC=4, ch0 active at 10, write ch0=200 at cnt=50 -> high time stays at 40 cycles for the current period, then becomes 800 of 1020 cycles from the next period_tick.
REQ-032 duty_valid held high with ch3=77 across the commit cycle -> duty_ready=0 for exactly that cycle, the write is accepted the next cycle, and 77 is applied one full period later.
REQ-033 en dropped at cnt=100 -> next clk cnt=0, pc=0, pwm_out=8'h00, and period_tick does not pulse; en re-raised -> counting resumes from cnt=0 with prior active duties retained.
REQ-034 rst asserted for one cycle in a commit cycle with nonzero shadows -> all outputs, shadows and actives read 0 on the next clk; no stale duty appears after reset.

Source files
------------

// File: rtl/led_pwm_mod.sv
// -----------------------------------------------------------------------------
// led_pwm_mod
//
// Eight-channel LED PWM modulator with glitch-free duty updates.
//
// A prescale counter divides clk by PRESC to produce a step strobe. Each step
// advances an 8-bit period counter through 0..254, so one PWM period lasts
// 255*PRESC clk cycles. Every channel compares the period counter against its
// active duty. Software writes go to per-channel shadow registers. All eight
// shadows are copied into the active registers together in the last cycle of
// a period (the commit cycle), so a duty change never takes effect part-way
// through a period.
//
// Parameters
//   PRESC        clk cycles per period-counter step, 1..65535
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous, active-high reset
//   en           modulator enable; low clears the counters and the outputs
//   ch_sel       channel addressed by a duty write
//   duty_in      duty value, 0 = always off, 255 = always on
//   duty_valid   write request qualifier
//   duty_ready   write can be accepted this cycle (low only in the commit cycle)
//   pwm_out      registered PWM drive, bit i = channel i
//   period_tick  one-cycle pulse in the first cycle of each new period
// -----------------------------------------------------------------------------
module led_pwm_mod #(
    parameter int unsigned PRESC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] ch_sel,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic [7:0] pwm_out,
    output logic       period_tick
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int          N_CH     = 8;
    // A width of at least one bit keeps the PRESC == 1 case legal; the
    // prescaler then sits at zero and every enabled cycle is a step.
    localparam int unsigned PC_W     = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PRESC - 1);
    localparam logic [7:0]      CNT_LAST = 8'd254;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PC_W-1:0]          pc_q,     pc_d;
    logic [7:0]               cnt_q,    cnt_d;
    logic [N_CH-1:0][7:0]     shadow_q, shadow_d;
    logic [N_CH-1:0][7:0]     active_q, active_d;
    logic [N_CH-1:0]          pwm_q,    pwm_d;
    logic                     tick_q,   tick_d;

    // -------------------------------------------------------------------------
    // Strobes
    // -------------------------------------------------------------------------
    logic step;
    logic commit;
    logic wr_en;

    always_comb begin
        step   = en && (pc_q == PC_LAST);
        // Last step of the period: the active duties swap in at this edge.
        commit = step && (cnt_q == CNT_LAST);
    end

    // Holding off writes in the commit cycle means a shadow can never change
    // in the same cycle it is being copied, so no write/commit collision
    // exists. A request held across the commit lands in the next cycle and is
    // picked up by the following commit.
    assign duty_ready = !commit;
    assign wr_en      = duty_valid && duty_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so that a path
        // that skips an assignment holds the value instead of inferring a latch.
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        pwm_d    = '0;
        tick_d   = commit;

        // Prescaler and period counter. Disabling clears both so the next
        // enable starts a clean period from cnt == 0.
        if (!en) begin
            pc_d  = '0;
            cnt_d = '0;
        end else begin
            if (pc_q == PC_LAST) begin
                pc_d = '0;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end

            if (step) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        end

        // Shadow writes are accepted whether or not the modulator runs.
        if (wr_en) begin
            shadow_d[ch_sel] = duty_in;
        end

        // All channels update together at the period boundary.
        if (commit) begin
            active_d = shadow_q;
        end

        // Unsigned compare: duty 0 never matches (always low) and duty 255
        // exceeds every counter value 0..254 (always high, no wrap glitch).
        if (en) begin
            for (int i = 0; i < N_CH; i++) begin
                pwm_d[i] = (cnt_q < active_q[i]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            cnt_q    <= '0;
            // NOTE: the duty register banks are cleared as well, so no stale
            // duty from before reset can reach an output after reset.
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= '0;
            tick_q   <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
            tick_q   <= tick_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_led_pwm_mod.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_mod
//
// Self-checking bench for led_pwm_mod. Two instances share one stimulus set:
// u_dut1 runs with PRESC = 1 and u_dut4 with PRESC = 4. Scenario tasks push
// the expected per-channel high time of a period onto a scoreboard queue;
// run_period() samples one full period of the selected instance, checks the
// period length through period_tick, then pops and compares every entry.
// -----------------------------------------------------------------------------
module tb_led_pwm_mod;

    localparam int P_A = 1;
    localparam int P_B = 4;

    typedef struct {
        int    ch;
        int    high;
        string tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] ch_sel;
    logic [7:0] duty_in;
    logic       duty_valid;

    logic       ready1, ready4;
    logic [7:0] pwm1,   pwm4;
    logic       tick1,  tick4;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    led_pwm_mod #(.PRESC(P_A)) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ch_sel      (ch_sel),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (ready1),
        .pwm_out     (pwm1),
        .period_tick (tick1)
    );

    led_pwm_mod #(.PRESC(P_B)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .ch_sel      (ch_sel),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (ready4),
        .pwm_out     (pwm4),
        .period_tick (tick4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- helpers
    function automatic logic [7:0] pwm_of(input int d);
        return (d == 0) ? pwm1 : pwm4;
    endfunction

    function automatic logic tick_of(input int d);
        return (d == 0) ? tick1 : tick4;
    endfunction

    function automatic logic ready_of(input int d);
        return (d == 0) ? ready1 : ready4;
    endfunction

    function automatic int presc_of(input int d);
        return (d == 0) ? P_A : P_B;
    endfunction

    task automatic push_exp(input int ch, input int high, input string tag);
        exp_t e;
        e.ch   = ch;
        e.high = high;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic push_all_zero(input string tag);
        for (int c = 0; c < 8; c++) push_exp(c, 0, tag);
    endtask

    // Present one write and hold it until both instances have accepted it.
    // Called and returns on a falling edge.
    task automatic drive_write(input logic [2:0] ch, input logic [7:0] val);
        bit acc0, acc1;
        int guard;
        acc0 = 1'b0;
        acc1 = 1'b0;
        guard = 0;
        ch_sel = ch;
        duty_in = val;
        duty_valid = 1'b1;
        while (!(acc0 && acc1) && guard < 8) begin
            if (ready1) acc0 = 1'b1;
            if (ready4) acc1 = 1'b1;
            @(negedge clk);
            guard++;
        end
        duty_valid = 1'b0;
        n_checks++;
        if (!(acc0 && acc1))
            $display("FAIL write_accept ch%0d: accepted dut1=%0d dut4=%0d, required 1/1", ch, acc0, acc1);
        else
            n_pass++;
    endtask

    // Advance on falling edges until period_tick of instance d is seen.
    task automatic wait_tick(input int d);
        int guard;
        guard = 0;
        while (tick_of(d) !== 1'b1 && guard < 2100) begin
            @(negedge clk);
            guard++;
        end
        if (tick_of(d) !== 1'b1) begin
            n_checks++;
            $display("FAIL wait_tick dut%0d: no period_tick within %0d cycles", d, guard);
        end
    endtask

    // Entered on the falling edge of the cycle in which the period starts
    // (period_tick high, or the first enabled cycle after reset/enable).
    // Samples the 255*PRESC following cycles, which carry the PWM for this
    // period, optionally injecting a single write at sample wr_k.
    task automatic run_period(input int d, input int wr_k, input logic [2:0] wr_ch,
                              input logic [7:0] wr_val, input string tag);
        int         hi[8];
        int         ticks;
        int         len;
        logic       last_tick;
        logic       tk;
        logic [7:0] p;
        exp_t       e;
        len = 255 * presc_of(d);
        for (int c = 0; c < 8; c++) hi[c] = 0;
        ticks = 0;
        last_tick = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            p = pwm_of(d);
            for (int c = 0; c < 8; c++) if (p[c] === 1'b1) hi[c]++;
            tk = tick_of(d);
            if (tk === 1'b1) ticks++;
            last_tick = tk;
            if (k == 1) duty_valid = 1'b0;
            if (k == wr_k) begin
                ch_sel = wr_ch;
                duty_in = wr_val;
                duty_valid = 1'b1;
            end
            if (k == wr_k + 1) duty_valid = 1'b0;
        end
        n_checks++;
        if (ticks != 1 || last_tick !== 1'b1)
            $display("FAIL %s period_len dut%0d: ticks=%0d last=%0b, required ticks=1 last=1 after %0d cycles",
                     tag, d, ticks, last_tick, len);
        else
            n_pass++;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (hi[e.ch] != e.high)
                $display("FAIL %s ch%0d high_time dut%0d: got %0d cycles, expected %0d",
                         e.tag, e.ch, d, hi[e.ch], e.high);
            else
                n_pass++;
        end
    endtask

    // Count falling edges until duty_ready of instance d drops.
    task automatic find_commit(input int d, input string tag, output int steps);
        steps = 0;
        while (ready_of(d) === 1'b1 && steps < 1100) begin
            @(negedge clk);
            steps++;
        end
        n_checks++;
        if (steps != 255 * presc_of(d) - 1)
            $display("FAIL %s commit_pos dut%0d: ready low after %0d cycles, expected %0d",
                     tag, d, steps, 255 * presc_of(d) - 1);
        else
            n_pass++;
    endtask

    // ---------------------------------------------------------------- scenarios
    task automatic test_reset;
        rst = 1'b1;
        en = 1'b0;
        duty_valid = 1'b0;
        ch_sel = 3'd0;
        duty_in = 8'd0;
        repeat (3) @(negedge clk);
        // A write during reset must be discarded.
        ch_sel = 3'd5;
        duty_in = 8'd99;
        duty_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({pwm1, tick1, ready1, pwm4, tick4, ready4} !== {8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1})
            $display("FAIL reset_state: pwm1=%h tick1=%b rdy1=%b pwm4=%h tick4=%b rdy4=%b, required 00/0/1 00/0/1",
                     pwm1, tick1, ready1, pwm4, tick4, ready4);
        else
            n_pass++;
    endtask

    task automatic test_first_period;
        // Release reset with en high and write ch0=128 in the very first cycle.
        rst = 1'b0;
        en = 1'b1;
        ch_sel = 3'd0;
        duty_in = 8'd128;
        duty_valid = 1'b1;
        push_all_zero("first_period");
        run_period(0, -1, 3'd0, 8'd0, "first_period");
        push_exp(0, 128, "duty128");
        push_exp(5, 0,   "reset_write_dropped");
        push_exp(1, 0,   "duty128_other");
        run_period(0, -1, 3'd0, 8'd0, "duty128");
    endtask

    task automatic test_const_duty;
        drive_write(3'd1, 8'd0);
        drive_write(3'd2, 8'd255);
        wait_tick(0);
        for (int n = 0; n < 3; n++) begin
            push_exp(0, 128, "const_ch0");
            push_exp(1, 0,   "const_duty0");
            push_exp(2, 255, "const_duty255");
            run_period(0, -1, 3'd0, 8'd0, "const");
        end
    endtask

    task automatic test_midperiod_update;
        drive_write(3'd0, 8'd10);
        wait_tick(1);
        // Write ch0=200 when cnt reaches 50 (4 clk per step).
        push_exp(0, 10 * P_B,  "mid_old_duty");
        push_exp(2, 255 * P_B, "mid_ch2");
        run_period(1, 50 * P_B, 3'd0, 8'd200, "mid_write");
        push_exp(0, 200 * P_B, "mid_new_duty");
        push_exp(2, 255 * P_B, "mid_ch2");
        run_period(1, -1, 3'd0, 8'd0, "mid_next");
    endtask

    task automatic test_back_to_back;
        int steps;
        find_commit(1, "b2b", steps);
        // Request presented in the commit cycle and held into the next one.
        ch_sel = 3'd3;
        duty_in = 8'd77;
        duty_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ready4, tick4} !== 2'b11)
            $display("FAIL b2b_after_commit: ready=%b tick=%b, required ready=1 tick=1", ready4, tick4);
        else
            n_pass++;
        push_exp(3, 0,        "b2b_not_yet");
        push_exp(0, 200 * P_B, "b2b_ch0");
        run_period(1, -1, 3'd0, 8'd0, "b2b_p1");
        push_exp(3, 77 * P_B,  "b2b_applied");
        push_exp(0, 200 * P_B, "b2b_ch0");
        run_period(1, -1, 3'd0, 8'd0, "b2b_p2");
    endtask

    task automatic test_enable;
        int bad;
        // Now at the start of a period of u_dut4: move to cnt == 100.
        repeat (100 * P_B) @(negedge clk);
        // Output here reflects cnt == 99: ch0(200) and ch2(255) high, ch3(77) low.
        n_checks++;
        if (pwm4 !== 8'h05)
            $display("FAIL en_before_drop: pwm=%h, required 05", pwm4);
        else
            n_pass++;
        en = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({pwm4, tick4, pwm1, tick1} !== {8'h00, 1'b0, 8'h00, 1'b0})
            $display("FAIL en_drop: pwm4=%h tick4=%b pwm1=%h tick1=%b, required 00/0/00/0",
                     pwm4, tick4, pwm1, tick1);
        else
            n_pass++;
        bad = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if ({pwm4, tick4, ready4, pwm1, tick1, ready1} !== {8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1}) bad++;
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL en_idle: %0d cycles with activity while disabled, required 0", bad);
        else
            n_pass++;
        // Re-enable: a full period starting at cnt == 0 with retained duties.
        en = 1'b1;
        push_exp(0, 200 * P_B, "en_resume_ch0");
        push_exp(1, 0,         "en_resume_ch1");
        push_exp(2, 255 * P_B, "en_resume_ch2");
        push_exp(3, 77 * P_B,  "en_resume_ch3");
        run_period(1, -1, 3'd0, 8'd0, "en_resume");
    endtask

    task automatic test_reset_in_commit;
        int steps;
        find_commit(1, "rst_commit", steps);
        rst = 1'b1;
        ch_sel = 3'd4;
        duty_in = 8'd33;
        duty_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({pwm4, tick4, ready4, pwm1, tick1} !== {8'h00, 1'b0, 1'b1, 8'h00, 1'b0})
            $display("FAIL rst_in_commit: pwm4=%h tick4=%b rdy4=%b pwm1=%h tick1=%b, required 00/0/1/00/0",
                     pwm4, tick4, ready4, pwm1, tick1);
        else
            n_pass++;
        rst = 1'b0;
        duty_valid = 1'b0;
        push_all_zero("post_rst_p1");
        run_period(1, -1, 3'd0, 8'd0, "post_rst_p1");
        push_all_zero("post_rst_p2");
        run_period(1, -1, 3'd0, 8'd0, "post_rst_p2");
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        rst = 1'b1;
        en = 1'b0;
        ch_sel = 3'd0;
        duty_in = 8'd0;
        duty_valid = 1'b0;
        @(negedge clk);
        test_reset;
        test_first_period;
        test_const_duty;
        test_midperiod_update;
        test_back_to_back;
        test_enable;
        test_reset_in_commit;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
